// File: rtl/os_array_ctrl.sv
// -----------------------------------------------------------------------------
// os_array_ctrl
//   Job sequencer for an N x N output-stationary systolic array of 16-bit MAC
//   PEs. For each start/done job it clears the PE accumulators, streams K
//   operand beats into the edge skew buffers, waits for the skewed wavefront
//   and the PE pipeline to drain, then hands the result rows out one by one
//   over a valid/ready handshake.
//
// Ports
//   CLK           clock
//   RST           asynchronous active-low reset
//   start_i       job request, sampled only while idle
//   k_len_i       accumulation depth, latched when start_i is accepted
//   out_ready_i   readout consumer accepts rd_row_o when high with rd_valid_o
//   busy_o        high in every state except idle
//   done_o        one-cycle pulse when the job completes
//   pe_clr_n_o    active-low accumulator clear to all PEs
//   feed_en_o     edge feeders present beat feed_idx_o (zero operands when low)
//   feed_idx_o    current K beat index
//   rd_row_o      result row selected onto the readout bus
//   rd_valid_o    rd_row_o data valid
// -----------------------------------------------------------------------------
module os_array_ctrl #(
  parameter int N        = 8,
  parameter int K_W      = 16,
  parameter int MULT_LAT = 2,
  parameter int ROW_W    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_i,
  input  logic [K_W-1:0]   k_len_i,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pe_clr_n_o,
  output logic             feed_en_o,
  output logic [K_W-1:0]   feed_idx_o,
  output logic [ROW_W-1:0] rd_row_o,
  output logic             rd_valid_o
);

  // Skew to PE[N-1][N-1], multiplier, product register, accumulate.
  localparam int DRAIN_CYC = 2 * (N - 1) + MULT_LAT + 2;
  localparam int DC_W      = $clog2(DRAIN_CYC);

  localparam logic [K_W-1:0]   K_ONE      = K_W'(1);
  localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYC - 1);
  localparam logic [DC_W-1:0]  DRAIN_ONE  = DC_W'(1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(N - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W-1:0]   feed_idx_q, feed_idx_d;
  logic [DC_W-1:0]  drain_q, drain_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic             busy_q, done_q, pe_clr_n_q, feed_en_q, rd_valid_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    feed_idx_d = feed_idx_q;
    drain_d    = drain_q;
    rd_row_d   = rd_row_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          k_d     = k_len_i;
        end
      end
      S_CLEAR: begin
        feed_idx_d = '0;
        rd_row_d   = '0;
        // A zero-depth job has nothing to feed or drain: results are all zero.
        state_d    = (k_q != '0) ? S_FEED : S_READ;
      end
      S_FEED: begin
        // Equality against k-1 so a full-range k never wraps the index early.
        if (feed_idx_q == k_q - K_ONE) begin
          state_d    = S_DRAIN;
          feed_idx_d = '0;
          drain_d    = DRAIN_LOAD;
        end else begin
          feed_idx_d = feed_idx_q + K_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d  = S_READ;
          rd_row_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      S_READ: begin
        // rd_valid is high throughout this state, so out_ready alone completes
        // the handshake.
        if (out_ready_i) begin
          if (rd_row_q == LAST_ROW) begin
            state_d  = S_DONE;
            rd_row_d = '0;
          end else begin
            rd_row_d = rd_row_q + ROW_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      feed_idx_q <= '0;
      drain_q    <= '0;
      rd_row_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pe_clr_n_q <= 1'b0;
      feed_en_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      feed_idx_q <= feed_idx_d;
      drain_q    <= drain_d;
      rd_row_q   <= rd_row_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      pe_clr_n_q <= (state_d != S_CLEAR);
      feed_en_q  <= (state_d == S_FEED);
      rd_valid_q <= (state_d == S_READ);
    end
  end

  // Job depth is data, only meaningful once a start has been accepted.
  always_ff @(posedge CLK) begin
    k_q <= k_d;
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pe_clr_n_o = pe_clr_n_q;
  assign feed_en_o  = feed_en_q;
  assign feed_idx_o = feed_idx_q;
  assign rd_row_o   = rd_row_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: doc/os_array_ctrl.md
Name: os_array_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of 16-bit MAC PEs (multiplier, product register, 32-bit accumulator).
- One start/done job per tile: clears the accumulators, streams K operand beats into the array's edge skew buffers, waits for the skewed wavefront and PE pipeline to drain, then reads the result rows out through a valid/ready handshake.
- Sits between the tile scheduler (start/done) and the array edge feeders and row readout mux.

Parameters:
- N, 8, array dimension (rows = columns); N >= 2.
- K_W, 16, width of the K-length and feed index.
- MULT_LAT, 2, PE multiplier latency in cycles, from operand at PE input to product valid.
- ROW_W, 3, width of the row index; must satisfy 2**ROW_W >= N.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  K_W  accumulation depth; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when the job completes.
- pe_clr_n  out  1  active-low accumulator clear to all PEs (drives PE RST).
- feed_en  out  1  edge feeders present beat feed_idx. While low, feeders must drive zero operands.
- feed_idx  out  K_W  current K beat index.
- rd_row  out  ROW_W  result row selected onto the readout bus.
- rd_valid  out  1  rd_row data valid.
- out_ready  in  1  consumer accepts the row when high together with rd_valid.

Behaviour:
- All outputs are registered.
- Reset values:
  - busy=0, done=0, feed_en=0, feed_idx=0, rd_row=0, rd_valid=0.
  - pe_clr_n=0: PEs are held cleared while the controller is in reset.
  - pe_clr_n rises on the first clock edge after RST deasserts.
- States: IDLE, CLEAR, FEED, DRAIN, READ, DONE.
- IDLE:
  - start=1 at edge t latches k_len into k_reg and enters CLEAR.
  - start in any other state is ignored; no queuing.
- CLEAR (1 cycle):
  - pe_clr_n=0 and busy=1.
  - Next state is FEED if k_reg != 0, otherwise READ; results are then all zero.
- FEED (k_reg cycles):
  - feed_en=1; feed_idx counts 0..k_reg-1, one increment per cycle.
  - On the cycle with feed_idx = k_reg-1, transition to DRAIN.
  - k_reg = 2**K_W - 1 must not wrap feed_idx early; the comparison is equality against k_reg-1.
- DRAIN (D = 2*(N-1) + MULT_LAT + 2 cycles):
  - feed_en=0; a down-counter is loaded with D-1 on entry.
  - 2*(N-1) covers skew to PE[N-1][N-1]; +MULT_LAT for the multiplier; +1 product register; +1 accumulate.
  - Transition to READ when the counter reaches 0.
- READ:
  - rd_valid=1 with rd_row starting at 0.
  - On rd_valid & out_ready, rd_row increments.
  - If the row accepted is N-1, drop rd_valid and go to DONE.
  - out_ready low holds rd_row and rd_valid stable indefinitely.
  - Accumulators keep their values because operands are zero.
- DONE (1 cycle): done=1 and busy=1, then IDLE with busy=0.
- A new start may be sampled on the cycle IDLE is re-entered. Back-to-back jobs therefore have one idle cycle.
- Asynchronous reset in any state:
  - Immediate return to IDLE with reset values.
  - pe_clr_n=0 clears the partially accumulated tile.
  - No done pulse is produced.
- Timing for start accepted at edge t and out_ready tied high:
  - CLEAR occupies t+1.
  - FEED occupies t+2 .. t+1+k.
  - DRAIN occupies the following D cycles.
  - READ occupies the following N cycles.
  - done is high in the next cycle, i.e. cycle t+2+k+D+N.

Test Plan:
- Reset release: RST low 3 cycles then high → all outputs at reset values during reset; pe_clr_n=1 one cycle after release; busy=0.
- Nominal job (N=8, MULT_LAT=2, k_len=4, out_ready=1):
  - pe_clr_n low for 1 cycle; feed_en high for 4 cycles with feed_idx 0,1,2,3; DRAIN 18 cycles.
  - rd_row 0..7 on 8 consecutive cycles; done pulse at t+32 and busy=0 at t+33.
  - Array results equal the reference 8x8x4 matrix product.
- k_len=0: start → CLEAR, then READ directly; no feed_en; 8 rows read as 0; done at t+10.
- Backpressure in READ: out_ready toggles 1,0,0,1,… → rd_row advances only on handshake cycles; rd_valid stays high; done only after row 7 is accepted.
- start ignored while busy: pulse start during FEED with a different k_len → no effect on feed_idx sequence or on k_reg.
- Reset mid-FEED at feed_idx=2 → immediate IDLE with pe_clr_n=0 and no done pulse. A following job with k_len=3 produces correct results with no leftover accumulation.
